stack_exec: RTL and testbench
=============================

// Module: stack_exec
// PURPOSE
//  Executes the one-cycle command codes issued by the button command FSM on an
//  integer stack. Supports push/pop, add/subtract of the top two entries,
//  reset, and a display pointer (TOP/INC/DEC).
//  Sits between the button FSM (iCmd) and the seven-segment/LED display logic.
// PARAMETERS
//  WIDTH  8   data width of each stack entry
//  DEPTH  16  number of stack entries, power of two
//  AW     4   clog2(DEPTH); derived, not overridden
// PORTS
//  iClk       in   1        system clock, all state on posedge
//  iRst       in   1        asynchronous, active-high reset
//  iCmd       in   5        command code, valid for one cycle; 0 = IDLE
//  iData      in   WIDTH    operand for PSH (switches), sampled on accept
//  oTop       out  WIDTH    top-of-stack value (0 when empty)
//  oCount     out  AW+1     number of entries, 0..DEPTH
//  oEmpty     out  1        oCount==0
//  oFull      out  1        oCount==DEPTH
//  oBusy      out  1        high while a multi-cycle command is in flight
//  oErr       out  1        sticky overflow/underflow flag
//  oDispAddr  out  AW       display pointer, 0 = bottom of stack
//  oDispData  out  WIDTH    entry at oDispAddr, registered
// BEHAVIOUR
//  Reset (iRst=1, async): FSM->S_IDLE; oTop, oCount, oErr, oDispAddr and oDispData
//   all 0; oEmpty=1; oFull=0; oBusy=0. Aborts any in-flight command; memory contents are don't-care.
//  Storage: TOS cached in register (oTop); entries 0..oCount-2 live in stack_ram.
//  Codes: IDLE=0 PSH=1 POP=2 ADD=3 SUB=4 TOP=5 RST=6 INC=7 DEC=8; 9..31 = IDLE.
//  Accept: a non-IDLE iCmd is accepted only in S_IDLE. Commands arriving while
//   oBusy=1 are dropped, never queued. Back-to-back pulses are separate commands.
//  PSH: full -> oErr=1, no change. Otherwise ram[oCount-1]<=oTop if oCount>0;
//   oTop<=iData; oCount++. Single cycle.
//  POP: empty -> oErr=1. oCount==1 -> oTop<=0, oCount<=0, single cycle.
//   Otherwise issue read ram[oCount-2] and go to S_FETCH. On the next cycle,
//   oTop<=rdata, oCount--, then back to S_IDLE. 2 cycles, oBusy high in S_FETCH.
//  ADD/SUB: oCount<2 -> oErr=1, no change. Otherwise read ram[oCount-2] into S_FETCH;
//   next cycle oTop<=rdata+oTop (ADD) or rdata-oTop (SUB; NOS minus TOS), oCount--.
//   Arithmetic modulo 2^WIDTH; no carry/borrow flag.
//  RST: single cycle, same result as iRst except it is synchronous.
//  TOP: oDispAddr<=oCount-1, or 0 if empty. INC/DEC: oDispAddr +/-1 modulo DEPTH.
//  oDispData (registered, 1-cycle lag): rTop if addr==oCount-1; ram[addr] if
//   addr<oCount-1; else 0. It reflects any write 1 cycle later.
//  FSM: S_IDLE -(POP/ADD/SUB with enough entries)-> S_FETCH -> S_IDLE. All
//   other commands complete in S_IDLE. oErr clears only on RST or iRst.
// STRUCTURE
//  Shared package stack_pkg: command code constants (CMD_IDLE..CMD_DEC),
//   also used by button_fsm, plus FSM state encodings.
//  Sub-module stack_ram: DEPTH x WIDTH regfile with 1 sync write port and 2
//   sync read ports (op port, display port); read-before-write on collision.
// TESTING
//  1 PSH 0x05, PSH 0x03, ADD -> oTop=0x08, oCount=1, oBusy high for 1 cycle.
//  2 PSH 0x02, PSH 0x07, SUB -> oTop=0xFB (2-7 wraps), oCount=1, oErr=0.
//  3 POP on empty and ADD with 1 entry -> oErr=1, oTop/oCount unchanged;
//    RST -> oErr=0.
//  4 Fill with 16 PSH (values 0..15), then 17th PSH -> oFull=1, oErr=1, oTop=15;
//    TOP -> oDispAddr=15; DEC x2 -> oDispData=13; INC from 15 -> wraps to 0.
//  5 PSH 0x01, PSH 0x02; POP, then PSH 0x09 one cycle later while busy -> PSH dropped,
//    oTop=0x01, oCount=1.
//  6 Assert iRst during S_FETCH of ADD -> all outputs 0 immediately, S_IDLE.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - command codes, FSM states and shared types for the stack executor
package stack_pkg;

    localparam logic [4:0] CMD_IDLE = 5'd0;
    localparam logic [4:0] CMD_PSH  = 5'd1;
    localparam logic [4:0] CMD_POP  = 5'd2;
    localparam logic [4:0] CMD_ADD  = 5'd3;
    localparam logic [4:0] CMD_SUB  = 5'd4;
    localparam logic [4:0] CMD_TOP  = 5'd5;
    localparam logic [4:0] CMD_RST  = 5'd6;
    localparam logic [4:0] CMD_INC  = 5'd7;
    localparam logic [4:0] CMD_DEC  = 5'd8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    typedef enum logic [1:0] {OP_POP, OP_ADD, OP_SUB} op_e;

    // Source of the display data register: nothing, the cached TOS, or the RAM display port.
    typedef enum logic [1:0] {DSEL_ZERO, DSEL_TOP, DSEL_RAM} dsel_e;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x WIDTH regfile, one sync write port, two sync read ports
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [AW-1:0]    daddr,
    output logic [WIDTH-1:0] ddata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reads sample the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
        ddata <= mem[daddr];
    end

endmodule

// File: rtl/stack_exec.sv
// rtl/stack_exec.sv - executes button command codes on an integer stack with cached TOS
module stack_exec
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [4:0]                iCmd,
    input  logic [WIDTH-1:0]          iData,
    output logic [WIDTH-1:0]          oTop,
    output logic [$clog2(DEPTH):0]    oCount,
    output logic                      oEmpty,
    output logic                      oFull,
    output logic                      oBusy,
    output logic                      oErr,
    output logic [$clog2(DEPTH)-1:0]  oDispAddr,
    output logic [WIDTH-1:0]          oDispData
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [0:0]       state;
    op_e              op_q;
    logic [WIDTH-1:0] top_q;
    logic [AW:0]      count_q;
    logic             err_q;
    logic [AW-1:0]    disp_addr_q;
    dsel_e            disp_sel_q;
    logic [WIDTH-1:0] disp_top_q;

    logic [AW:0]      count_m1;
    logic [AW:0]      count_m2;
    logic [AW:0]      disp_addr_p1;
    logic             empty;
    logic             full;
    logic             ram_we;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] ddata;

    assign count_m1     = count_q - 1'b1;
    assign count_m2     = count_q - 2'd2;
    assign disp_addr_p1 = {1'b0, disp_addr_q} + 1'b1;
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_COUNT);

    // Pushing onto a non-empty stack spills the cached TOS into the RAM slot below the new top.
    assign ram_we = (state == S_IDLE) && (iCmd == CMD_PSH) && !full && !empty;

    stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (iClk),
        .we    (ram_we),
        .waddr (count_m1[AW-1:0]),
        .wdata (top_q),
        .raddr (count_m2[AW-1:0]),
        .rdata (rdata),
        .daddr (disp_addr_q),
        .ddata (ddata)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state       <= S_IDLE;
            op_q        <= OP_POP;
            top_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            disp_addr_q <= '0;
            disp_sel_q  <= DSEL_ZERO;
            disp_top_q  <= '0;
        end else begin
            disp_top_q <= top_q;
            if (disp_addr_p1 == count_q)
                disp_sel_q <= DSEL_TOP;
            else if (disp_addr_p1 < count_q)
                disp_sel_q <= DSEL_RAM;
            else
                disp_sel_q <= DSEL_ZERO;

            if (state == S_FETCH) begin
                case (op_q)
                    OP_ADD:  top_q <= rdata + top_q;
                    OP_SUB:  top_q <= rdata - top_q;
                    default: top_q <= rdata;
                endcase
                count_q <= count_m1;
                state   <= S_IDLE;
            end else begin
                case (iCmd)
                    CMD_PSH: begin
                        if (full) begin
                            err_q <= 1'b1;
                        end else begin
                            top_q   <= iData;
                            count_q <= count_q + 1'b1;
                        end
                    end
                    CMD_POP: begin
                        if (empty) begin
                            err_q <= 1'b1;
                        end else if (count_q == (AW+1)'(1)) begin
                            top_q   <= '0;
                            count_q <= '0;
                        end else begin
                            op_q  <= OP_POP;
                            state <= S_FETCH;
                        end
                    end
                    CMD_ADD, CMD_SUB: begin
                        if (count_q < (AW+1)'(2)) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q  <= (iCmd == CMD_ADD) ? OP_ADD : OP_SUB;
                            state <= S_FETCH;
                        end
                    end
                    CMD_RST: begin
                        top_q       <= '0;
                        count_q     <= '0;
                        err_q       <= 1'b0;
                        disp_addr_q <= '0;
                        disp_sel_q  <= DSEL_ZERO;
                        disp_top_q  <= '0;
                    end
                    CMD_TOP: disp_addr_q <= empty ? '0 : count_m1[AW-1:0];
                    CMD_INC: disp_addr_q <= disp_addr_q + 1'b1;
                    CMD_DEC: disp_addr_q <= disp_addr_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        oDispData = '0;
        case (disp_sel_q)
            DSEL_TOP: oDispData = disp_top_q;
            DSEL_RAM: oDispData = ddata;
            default:  oDispData = '0;
        endcase
    end

    assign oTop      = top_q;
    assign oCount    = count_q;
    assign oEmpty    = empty;
    assign oFull     = full;
    assign oBusy     = (state == S_FETCH);
    assign oErr      = err_q;
    assign oDispAddr = disp_addr_q;

endmodule

// File: tb/tb_stack_exec.sv
// tb/tb_stack_exec.sv - self-checking bench for stack_exec
module tb_stack_exec;

    localparam logic [4:0] C_IDLE = 5'd0, C_PSH = 5'd1, C_POP = 5'd2, C_ADD = 5'd3,
                           C_SUB = 5'd4, C_TOP = 5'd5, C_RST = 5'd6, C_INC = 5'd7,
                           C_DEC = 5'd8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cmd = C_IDLE;
    logic [7:0] data = '0;
    logic [7:0] top;
    logic [4:0] count;
    logic       empty, full, busy, err;
    logic [3:0] disp_addr;
    logic [7:0] disp_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] cmd;
        logic [7:0] data;
        int         top;
        int         count;
        int         err;
        int         busy;
    } vec_t;

    typedef struct {
        int top;
        int count;
        int err;
        int busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    stack_exec dut (
        .iClk      (clk),
        .iRst      (rst),
        .iCmd      (cmd),
        .iData     (data),
        .oTop      (top),
        .oCount    (count),
        .oEmpty    (empty),
        .oFull     (full),
        .oBusy     (busy),
        .oErr      (err),
        .oDispAddr (disp_addr),
        .oDispData (disp_data)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] c, input logic [7:0] d, input int t,
                                input int n, input int e, input int b);
        vec_t v;
        v.cmd = c; v.data = d; v.top = t; v.count = n; v.err = e; v.busy = b;
        return v;
    endfunction

    task automatic pulse(input logic [4:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd = c; data = d;
        @(negedge clk);
        cmd = C_IDLE;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   n;
        e.top = v.top; e.count = v.count; e.err = v.err; e.busy = v.busy;
        sb.push_back(e);
        pulse(v.cmd, v.data);
        n = 0;
        while (busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d_busy_cycles", idx), n, e.busy);
        chk($sformatf("v%0d_top", idx), int'(top), e.top);
        chk($sformatf("v%0d_count", idx), int'(count), e.count);
        chk($sformatf("v%0d_err", idx), int'(err), e.err);
        chk($sformatf("v%0d_empty", idx), int'(empty), int'(e.count == 0));
        chk($sformatf("v%0d_full", idx), int'(full), int'(e.count == 16));
    endtask

    initial begin
        // Reset state, checked while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_top", int'(top), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_daddr", int'(disp_addr), 0);
        chk("rst_ddata", int'(disp_data), 0);
        rst = 1'b0;

        vecs.push_back(mk(C_PSH, 8'h05, 'h05, 1, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h03, 'h03, 2, 0, 0));
        vecs.push_back(mk(C_ADD, 8'h00, 'h08, 1, 0, 1));
        vecs.push_back(mk(C_POP, 8'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h02, 'h02, 1, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h07, 'h07, 2, 0, 0));
        vecs.push_back(mk(C_SUB, 8'h00, 'hFB, 1, 0, 1));
        vecs.push_back(mk(C_POP, 8'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(C_POP, 8'h00, 'h00, 0, 1, 0));
        vecs.push_back(mk(C_PSH, 8'h04, 'h04, 1, 1, 0));
        vecs.push_back(mk(C_ADD, 8'h00, 'h04, 1, 1, 0));
        vecs.push_back(mk(C_RST, 8'h00, 'h00, 0, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h11, 'h11, 1, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h22, 'h22, 2, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h33, 'h33, 3, 0, 0));
        vecs.push_back(mk(C_POP, 8'h00, 'h22, 2, 0, 1));
        vecs.push_back(mk(C_SUB, 8'h00, 'hEF, 1, 0, 1));
        vecs.push_back(mk(5'd20, 8'h55, 'hEF, 1, 0, 0));
        vecs.push_back(mk(C_RST, 8'h00, 'h00, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(C_PSH, 8'(i), i, i + 1, 0, 0));
        vecs.push_back(mk(C_PSH, 8'h99, 'h0F, 16, 1, 0));

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // Display pointer over the full stack.
        pulse(C_TOP, 8'h00);
        chk("top_daddr", int'(disp_addr), 15);
        @(negedge clk);
        chk("top_ddata", int'(disp_data), 15);
        pulse(C_DEC, 8'h00);
        pulse(C_DEC, 8'h00);
        chk("dec2_daddr", int'(disp_addr), 13);
        @(negedge clk);
        chk("dec2_ddata", int'(disp_data), 13);
        pulse(C_TOP, 8'h00);
        pulse(C_INC, 8'h00);
        chk("inc_wrap_daddr", int'(disp_addr), 0);
        @(negedge clk);
        chk("inc_wrap_ddata", int'(disp_data), 0);
        pulse(C_INC, 8'h00);
        pulse(C_INC, 8'h00);
        @(negedge clk);
        chk("inc2_ddata", int'(disp_data), 2);
        pulse(C_DEC, 8'h00);
        pulse(C_DEC, 8'h00);
        pulse(C_DEC, 8'h00);
        chk("dec_wrap_daddr", int'(disp_addr), 15);

        // Display reflects a spilled entry once it has moved into RAM.
        pulse(C_RST, 8'h00);
        chk("rst_cmd_daddr", int'(disp_addr), 0);
        chk("rst_cmd_ddata", int'(disp_data), 0);
        pulse(C_PSH, 8'hA1);
        @(negedge clk);
        chk("disp_tos_ddata", int'(disp_data), 'hA1);
        pulse(C_PSH, 8'hB2);
        @(negedge clk);
        chk("disp_ram_ddata", int'(disp_data), 'hA1);
        pulse(C_INC, 8'h00);
        @(negedge clk);
        chk("disp_new_tos_ddata", int'(disp_data), 'hB2);
        pulse(C_INC, 8'h00);
        @(negedge clk);
        chk("disp_above_ddata", int'(disp_data), 0);

        // PSH presented while POP is in S_FETCH is dropped.
        pulse(C_RST, 8'h00);
        pulse(C_PSH, 8'h01);
        pulse(C_PSH, 8'h02);
        @(negedge clk);
        cmd = C_POP;
        @(negedge clk);
        chk("drop_busy", int'(busy), 1);
        cmd = C_PSH; data = 8'h09;
        @(negedge clk);
        cmd = C_IDLE;
        chk("drop_busy_after", int'(busy), 0);
        @(negedge clk);
        chk("drop_top", int'(top), 1);
        chk("drop_count", int'(count), 1);
        chk("drop_err", int'(err), 0);

        // Asynchronous reset in the middle of an ADD.
        pulse(C_POP, 8'h00);
        pulse(C_POP, 8'h00);
        pulse(C_PSH, 8'h05);
        pulse(C_PSH, 8'h03);
        pulse(C_TOP, 8'h00);
        @(negedge clk);
        cmd = C_ADD;
        @(negedge clk);
        cmd = C_IDLE;
        chk("abort_busy_before", int'(busy), 1);
        chk("abort_err_before", int'(err), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_top", int'(top), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_empty", int'(empty), 1);
        chk("abort_daddr", int'(disp_addr), 0);
        chk("abort_ddata", int'(disp_data), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse(C_PSH, 8'h07);
        chk("post_abort_top", int'(top), 7);
        chk("post_abort_count", int'(count), 1);
        chk("post_abort_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
